// File: rtl/fpu_lzc_pkg.sv
// -----------------------------------------------------------------------------
// fpu_lzc_pkg
// Shared constants and helpers for the FPU leading-one / leading-zero encoders.
//
// Contents
//   LZCnn_XLEN / LZCnn_XLOG : operand width and matching index width for the
//                             widths used in the normalisation path.
//   lzc_width_ok()          : elaboration-time check that an (XLEN, XLOG) pair
//                             is a supported power-of-two combination.
// -----------------------------------------------------------------------------
package fpu_lzc_pkg;

  localparam int LZC16_XLEN  = 16;
  localparam int LZC16_XLOG  = 4;
  localparam int LZC32_XLEN  = 32;
  localparam int LZC32_XLOG  = 5;
  localparam int LZC64_XLEN  = 64;
  localparam int LZC64_XLOG  = 6;
  localparam int LZC128_XLEN = 128;
  localparam int LZC128_XLOG = 7;
  localparam int LZC256_XLEN = 256;
  localparam int LZC256_XLOG = 8;

  // Supported range is 4..256 bits, and XLOG must be exactly log2(XLEN).
  function automatic bit lzc_width_ok(input int xlen, input int xlog);
    return (xlog >= 2) && (xlog <= 8) && (xlen == (1 << xlog));
  endfunction

endpackage

// File: rtl/lzc_merge.sv
// -----------------------------------------------------------------------------
// lzc_merge
// Combines the leading-one results of the high and low halves of an operand
// into the result for the full (double-width) operand.
//
// Parameters
//   W  : index width of each half-width result.
//
// Ports
//   vh, ch : valid flag and index from the upper half.
//   vl, cl : valid flag and index from the lower half.
//   v      : valid flag of the combined operand (any bit set).
//   c      : index of the combined operand; the MSB selects the half.
// -----------------------------------------------------------------------------
module lzc_merge #(
  parameter int W = 1
) (
  input  logic         vh,
  input  logic [W-1:0] ch,
  input  logic         vl,
  input  logic [W-1:0] cl,
  output logic         v,
  output logic [W:0]   c
);

  assign v = vh | vl;

  // The upper half wins whenever it holds any set bit; the lower half is
  // ignored then. With both halves empty cl is zero, so c stays zero.
  assign c = vh ? {1'b1, ch} : {1'b0, cl};

endmodule

// File: rtl/lzc_pos.sv
// -----------------------------------------------------------------------------
// lzc_pos
// Registered leading-one position encoder (inverted leading-zero counter) for
// the FPU normalisation path. The leading-zero count is ~c.
//
// Parameters
//   XLEN : operand width, power of two, 4..256.
//   XLOG : index width, log2(XLEN).
//
// Ports
//   clock : rising-edge clock.
//   reset : asynchronous active-high reset; clears c and v.
//   a     : operand, sampled every rising edge.
//   c     : index of the highest set bit of the sampled a (0 when a == 0).
//   v     : high when the sampled a was nonzero.
// -----------------------------------------------------------------------------
module lzc_pos
  import fpu_lzc_pkg::*;
#(
  parameter int XLEN = LZC256_XLEN,
  parameter int XLOG = LZC256_XLOG
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] a,
  output logic [XLOG-1:0] c,
  output logic            v
);

  if (!lzc_width_ok(XLEN, XLOG)) begin : g_bad_width
    $error("lzc_pos: XLEN must be 2**XLOG with XLEN in 4..256");
  end

  // Binary tree of XLOG levels. Level l holds XLEN>>(l+1) nodes, each
  // covering 2**(l+1) operand bits with an (l+1)-bit index. Node i of level
  // l merges nodes 2i+1 (upper) and 2i (lower) of level l-1.
  for (genvar l = 0; l < XLOG; l++) begin : g_lvl
    localparam int N = XLEN >> (l + 1);

    logic [l:0] node_c [N];
    logic       node_v [N];

    for (genvar i = 0; i < N; i++) begin : g_node
      if (l == 0) begin : g_leaf
        // A 2-bit pair: the index is simply whether the upper bit is set.
        assign node_v[i] = a[2*i+1] | a[2*i];
        assign node_c[i] = a[2*i+1];
      end else begin : g_mrg
        lzc_merge #(.W(l)) u_merge (
          .vh (g_lvl[l-1].node_v[2*i+1]),
          .ch (g_lvl[l-1].node_c[2*i+1]),
          .vl (g_lvl[l-1].node_v[2*i]),
          .cl (g_lvl[l-1].node_c[2*i]),
          .v  (node_v[i]),
          .c  (node_c[i])
        );
      end
    end
  end

  logic [XLOG-1:0] root_c;
  logic            root_v;

  assign root_c = g_lvl[XLOG-1].node_c[0];
  assign root_v = g_lvl[XLOG-1].node_v[0];

  // Output register: the only state in the block. An in-flight result is
  // discarded by reset; the first edge after release registers the live a.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      c <= '0;
      v <= 1'b0;
    end else begin
      c <= root_c;
      v <= root_v;
    end
  end

endmodule

// File: tb/tb_lzc_pos.sv
// -----------------------------------------------------------------------------
// tb_lzc_pos
// Self-checking bench for lzc_pos at XLEN = 256, 16 and 128. All three
// instances share clock and reset. Expected results come from a linear scan
// for the highest set bit, or from hand-written constants.
// -----------------------------------------------------------------------------
module tb_lzc_pos;

  logic clock = 1'b0;
  logic reset;

  logic [255:0] a256;
  logic [7:0]   c256;
  logic         v256;
  logic [15:0]  a16;
  logic [3:0]   c16;
  logic         v16;
  logic [127:0] a128;
  logic [6:0]   c128;
  logic         v128;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  lzc_pos #(.XLEN(256), .XLOG(8)) u_dut256 (
    .clock (clock), .reset (reset), .a (a256), .c (c256), .v (v256));
  lzc_pos #(.XLEN(16), .XLOG(4)) u_dut16 (
    .clock (clock), .reset (reset), .a (a16), .c (c16), .v (v16));
  lzc_pos #(.XLEN(128), .XLOG(7)) u_dut128 (
    .clock (clock), .reset (reset), .a (a128), .c (c128), .v (v128));

  typedef struct {
    logic [255:0] a;
    int           exp_c;
    bit           exp_v;
  } vec_t;

  vec_t tbl [9];

  // Reference: position of the highest set bit among the low n bits, -1 if none.
  function automatic int ref_msb(input logic [255:0] x, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      if (x[i]) return i;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Compare all three instances against expected msb positions (-1 = zero).
  task automatic check_all(input string tag, input int p256, input int p16, input int p128);
    check({tag, " c256"}, 32'(c256), (p256 < 0) ? 0 : p256);
    check({tag, " v256"}, 32'(v256), 32'(p256 >= 0));
    check({tag, " c16"},  32'(c16),  (p16 < 0) ? 0 : p16);
    check({tag, " v16"},  32'(v16),  32'(p16 >= 0));
    check({tag, " c128"}, 32'(c128), (p128 < 0) ? 0 : p128);
    check({tag, " v128"}, 32'(v128), 32'(p128 >= 0));
  endtask

  // Drive operands away from the active edge, then sample just after it.
  task automatic apply(input logic [255:0] x256, input logic [15:0] x16, input logic [127:0] x128);
    @(negedge clock);
    a256 = x256;
    a16  = x16;
    a128 = x128;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] r;
    logic [255:0] one;
    logic [7:0]   lz;
    int           prev256;

    one = 256'd1;
    tbl[0] = '{256'd0, 0, 1'b0};
    tbl[1] = '{256'd1, 0, 1'b1};
    tbl[2] = '{256'h500, 10, 1'b1};
    tbl[3] = '{{256{1'b1}}, 255, 1'b1};
    tbl[4] = '{{1'b1, 255'b0} | 256'd1, 255, 1'b1};
    tbl[5] = '{256'h8000, 15, 1'b1};
    tbl[6] = '{256'hFF, 7, 1'b1};
    tbl[7] = '{256'd1 << 127, 127, 1'b1};
    tbl[8] = '{256'hF0F0_0000_0000_0000_0000, 79, 1'b1};

    // ---- reset state, including an edge while reset is held ----
    reset = 1'b1;
    a256  = '1;
    a16   = '1;
    a128  = '1;
    #1;
    check_all("reset_async", -1, -1, -1);
    @(posedge clock);
    #1;
    check_all("reset_held", -1, -1, -1);

    // First edge after release registers the operand present at that edge.
    @(negedge clock);
    reset = 1'b0;
    a256  = 256'h500;
    a16   = 16'h0500;
    a128  = 128'h500;
    @(posedge clock);
    #1;
    check_all("first_edge", 10, 10, 10);

    // ---- table vectors ----
    foreach (tbl[i]) begin
      apply(tbl[i].a, tbl[i].a[15:0], tbl[i].a[127:0]);
      check($sformatf("tbl%0d c256", i), 32'(c256), tbl[i].exp_c);
      check($sformatf("tbl%0d v256", i), 32'(v256), 32'(tbl[i].exp_v));
      check($sformatf("tbl%0d c16", i), 32'(c16),
            (ref_msb(tbl[i].a, 16) < 0) ? 0 : ref_msb(tbl[i].a, 16));
      check($sformatf("tbl%0d c128", i), 32'(c128),
            (ref_msb(tbl[i].a, 128) < 0) ? 0 : ref_msb(tbl[i].a, 128));
    end

    // ---- walking one on all widths ----
    for (int k = 0; k < 256; k++) begin
      apply(one << k, 16'(one << (k % 16)), 128'(one << (k % 128)));
      check_all($sformatf("walk%0d", k), k, k % 16, k % 128);
      lz = ~c256;
      check($sformatf("walk%0d lzc256", k), 32'(lz), 255 - k);
    end

    // ---- zero operand, then a = 1 distinguished by v ----
    apply('0, '0, '0);
    check_all("zero", -1, -1, -1);
    apply(256'd1, 16'd1, 128'd1);
    check_all("one", 0, 0, 0);
    apply(256'h8000, 16'h8000, 128'd1 << 127);
    check_all("top_bits", 15, 15, 127);

    // ---- reset asserted mid-stream, between edges ----
    apply(one << 200, 16'h0010, 128'd1 << 100);
    check_all("pre_reset", 200, 4, 100);
    #2;
    reset = 1'b1;
    #1;
    check_all("reset_mid", -1, -1, -1);
    @(negedge clock);
    reset = 1'b0;
    a256  = one << 7;
    a16   = 16'd1 << 7;
    a128  = 128'd1 << 7;
    @(posedge clock);
    #1;
    check_all("post_reset", 7, 7, 7);

    // ---- random back-to-back operands ----
    prev256 = 7;
    for (int n = 0; n < 10000; n++) begin
      for (int j = 0; j < 8; j++) r[32*j +: 32] = $urandom;
      r = r >> $urandom_range(0, 256);
      if ($urandom_range(0, 15) == 0) r = '0;
      @(negedge clock);
      a256 = r;
      a16  = r[15:0];
      a128 = r[127:0];
      #1;
      // The new operand must not reach c before the next edge.
      check("rand hold c256", 32'(c256), (prev256 < 0) ? 0 : prev256);
      @(posedge clock);
      #1;
      check_all("rand", ref_msb(r, 256), ref_msb(r, 16), ref_msb(r, 128));
      prev256 = ref_msb(r, 256);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
